// File: rtl/cmd_arbiter.sv
// Two-requester command arbiter: round-robin header grant, then forwards
// op/data word pairs from the owning requester to a single stream output.
module cmd_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ack,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              frame_err,
    output logic              pair_err
);

    typedef enum logic [1:0] {IDLE, OP, DAT} state_t;

    localparam logic [7:0] HDR_TAG = 8'h64;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic              pair_err_q, pair_err_d;
    logic              last_q, last_d;

    logic              sel;
    logic [DATA_W-1:0] sel_word;
    logic              any_valid;
    logic              is_hdr;
    logic              owner;
    logic              own_valid;
    logic [DATA_W-1:0] own_word;

    // Tie goes to the requester that was not granted last.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        sel       = (req0_valid & req1_valid) ? ~last_q : req1_valid;
        sel_word  = sel ? req1_data : req0_data;
        is_hdr    = (sel_word[27:20] == HDR_TAG);
        owner     = grant_q[1];
        own_valid = owner ? req1_valid : req0_valid;
        own_word  = owner ? req1_data : req0_data;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        grant_d      = grant_q;
        busy_d       = busy_q;
        frame_err_d  = 1'b0;
        pair_err_d   = 1'b0;
        last_d       = last_q;
        req0_ack     = 1'b0;
        req1_ack     = 1'b0;

        if (enable && !clear) begin
            unique case (state_q)
                IDLE: begin
                    data_out_d = '0;
                    if (ready_in && any_valid) begin
                        req0_ack = ~sel;
                        req1_ack = sel;
                        if (is_hdr) begin
                            data_out_d   = sel_word;
                            data_valid_d = 1'b1;
                            last_d       = sel;
                            if (sel_word[19:16] == 4'd0 && sel_word[CNT_W-1:0] != '0) begin
                                cnt_d   = sel_word[CNT_W-1:0];
                                grant_d = sel ? 2'b10 : 2'b01;
                                busy_d  = 1'b1;
                                state_d = OP;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                OP: begin
                    data_out_d = '0;
                    if (own_valid && ready_in) begin
                        req0_ack     = ~owner;
                        req1_ack     = owner;
                        data_out_d   = own_word;
                        data_valid_d = 1'b1;
                        state_d      = DAT;
                    end
                end
                DAT: begin
                    // Data half is always emitted; a missing word becomes zero.
                    data_valid_d = 1'b1;
                    if (own_valid) begin
                        req0_ack   = ~owner;
                        req1_ack   = owner;
                        data_out_d = own_word;
                    end else begin
                        data_out_d = '0;
                        pair_err_d = 1'b1;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        busy_d  = 1'b0;
                        last_d  = owner;
                    end else begin
                        state_d = OP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            pair_err_q   <= 1'b0;
            last_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            pair_err_q   <= pair_err_d;
            last_q       <= last_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign pair_err   = pair_err_q;

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 Parameter DATA_W, 32, command word width; only 32 is supported.
REQ-002 Parameter CNT_W, 16, width of the frame pair counter; equals header count field [15:0].
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  global enable; state frozen when low.
REQ-006 req0_valid / req1_valid  input  1  requester N presents a word.
REQ-007 req0_data / req1_data  input  32  requester N command word.
REQ-008 req0_ack / req1_ack  output  1  combinational; word accepted this cycle.
REQ-009 ready_in  input  1  downstream stream-interface ready.
REQ-010 data_out  output  32  registered word to downstream stream interface.
REQ-011 data_valid  output  1  registered; data_out carries a forwarded word.
REQ-012 grant  output  2  registered one-hot owner of current frame; 00 when idle.
REQ-013 busy  output  1  registered; high while a frame is open.
REQ-014 frame_err  output  1  one-cycle pulse; non-header word dropped in IDLE.
REQ-015 pair_err  output  1  one-cycle pulse; data half of pair missing, 0 substituted.

Function
REQ-016 Header word: [27:20]==8'h64; type=[19:16]; count=[15:0].
REQ-017 States: IDLE, OP, DAT; reset state IDLE.
REQ-018 Transfer occurs only when enable=1; with enable=0, acks=0, data_valid<=0, data_out/state/counters hold.
REQ-019 IDLE, ready_in=1: pick among valid requesters round-robin (requester not granted last wins a tie; sole valid wins); assert its ack that cycle.
REQ-020 IDLE accepted header type 0, count>0: forward word, load counter=count, grant<=selected, busy<=1, go OP.
REQ-021 IDLE accepted header type 0 with count=0, or type 1/2/other: forward word, stay IDLE, grant stays 00, last-grant updated.
REQ-022 IDLE accepted non-header word: dropped (ack=1, data_valid<=0), frame_err<=1 for one cycle, stay IDLE, last-grant unchanged.
REQ-023 IDLE, ready_in=0 or no valid requester: no ack, data_out<=0, data_valid<=0.
REQ-024 OP: only granted requester acked; transfer when its valid=1 and ready_in=1; forward op word, go DAT.
REQ-025 OP without transfer: data_out<=0, data_valid<=0 (zero op word is idle-safe downstream); other requester never acked.
REQ-026 DAT: independent of ready_in; if granted valid=1, ack and forward word; else data_out<=0, data_valid<=1, pair_err<=1; counter decrements either way.
REQ-027 DAT with counter reaching 0 (pre-decrement 1): go IDLE, grant<=00, busy<=0, last-grant<=owner; else go OP.
REQ-028 Forwarded word appears on data_out exactly 1 cycle after its ack (latency 1); at most one ack per cycle; never both acks.
REQ-029 Non-grant requester valid during open frame: no ack, waits; round-robin guarantees it next frame.
REQ-030 Counter is CNT_W bits, no wrap: count 16'hFFFF yields 65535 pairs.

Reset
REQ-031 clear=1 overrides enable: state<=IDLE, counter<=0, data_out<=0, data_valid<=0, grant<=00, busy<=0, frame_err<=0, pair_err<=0, last-grant<=requester 1 (requester 0 wins first tie).
REQ-032 Acks are 0 during any clear cycle; clear mid-frame abandons the frame with no further words forwarded.

Verification
REQ-033 Both valid with header 0x0640_0002 after reset -> req0_ack first; 0x06400002, op, data, op, data forwarded on 5 consecutive cycles (1-cycle lag); grant=01 throughout, then req1 granted.
REQ-034 req0 presents 0x0000_0005 in IDLE -> req0_ack=1, frame_err pulse, data_valid stays 0, state IDLE.
REQ-035 Header 0x0640_0001 then op, then req0_valid low on DAT cycle -> data_out=0 with data_valid=1, pair_err pulse, return IDLE, grant=00.
REQ-036 ready_in held low in OP for 3 cycles -> no ack, data_out=0, data_valid=0; on ready_in=1 op forwarded next cycle.
REQ-037 Header 0x0642_004F (size) from req1 -> forwarded, state IDLE, grant 00; clear asserted mid-frame of a count-3 frame -> all outputs reset next cycle, no more acks.
